// File: rtl/uart_cpu_regs.sv
// CPU-side register file for the UART: decodes STATUS/CONTROL/TX/RX, holds the
// core configuration, generates start pulses and keeps the sticky status flags.
module uart_cpu_regs #(
  parameter int CPU_ADDR_WIDTH  = 2,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int UART_DATA_WIDTH = 9
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_cpu_i,
  input  logic                       rd_en_cpu_i,
  input  logic [CPU_ADDR_WIDTH-1:0]  cpu_addr_i,
  input  logic [CPU_DATA_WIDTH-1:0]  cpu_data_i,
  output logic [CPU_DATA_WIDTH-1:0]  cpu_data_o,
  output logic                       tx_en_o,
  output logic                       rx_en_o,
  output logic                       tx_start_o,
  output logic                       rx_start_o,
  output logic                       tx_parity_en_o,
  output logic                       rx_parity_en_o,
  output logic [1:0]                 tx_stop_sel_o,
  output logic [1:0]                 rx_stop_sel_o,
  output logic [1:0]                 tx_data_sel_o,
  output logic [1:0]                 rx_data_sel_o,
  output logic [1:0]                 baud_sel_o,
  output logic [UART_DATA_WIDTH-1:0] tx_data_o,
  input  logic                       tx_done_i,
  input  logic                       rx_done_i,
  input  logic                       tx_busy_i,
  input  logic                       rx_busy_i,
  input  logic [UART_DATA_WIDTH-1:0] rx_data_i
);

  // Stop-width code 3 has no meaning on the line; clamp it to the widest legal value.
  function automatic logic [1:0] sat_stop(input logic [1:0] v);
    return (v == 2'd3) ? 2'd2 : v;
  endfunction

  logic                       tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  logic                       tx_start_q, tx_start_d, rx_start_q, rx_start_d;
  logic                       tx_par_q, tx_par_d, rx_par_q, rx_par_d;
  logic [1:0]                 tx_stop_q, tx_stop_d, rx_stop_q, rx_stop_d;
  logic [1:0]                 tx_dsel_q, tx_dsel_d, rx_dsel_q, rx_dsel_d;
  logic [1:0]                 baud_q, baud_d;
  logic [UART_DATA_WIDTH-1:0] tx_data_q, tx_data_d, rx_data_q, rx_data_d;
  logic                       tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic                       rx_ovr_q, rx_ovr_d;
  logic [CPU_DATA_WIDTH-1:0]  cpu_data_q, cpu_data_d;

  logic        wr_ctrl, wr_tx, rd_status, rd_rx;
  logic [31:0] rd_word, d32;
  logic        unused_data;

  assign d32         = 32'(cpu_data_i);
  assign unused_data = ^cpu_data_i;

  always_comb begin
    tx_en_d    = tx_en_q;
    rx_en_d    = rx_en_q;
    tx_par_d   = tx_par_q;
    rx_par_d   = rx_par_q;
    tx_stop_d  = tx_stop_q;
    rx_stop_d  = rx_stop_q;
    tx_dsel_d  = tx_dsel_q;
    rx_dsel_d  = rx_dsel_q;
    baud_d     = baud_q;
    tx_data_d  = tx_data_q;
    rx_data_d  = rx_data_q;
    cpu_data_d = cpu_data_q;
    rd_word    = 32'd0;

    wr_ctrl   = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(1));
    wr_tx     = wr_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(2));
    rd_status = rd_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(0));
    rd_rx     = rd_en_cpu_i && (cpu_addr_i == CPU_ADDR_WIDTH'(3));

    // Start pulses qualify on the enable held before this write as well as the written one.
    tx_start_d = wr_ctrl && d32[1]  && (d32[0]  || tx_en_q) && !tx_busy_i;
    rx_start_d = wr_ctrl && d32[17] && (d32[16] || rx_en_q) && !rx_busy_i;

    if (wr_ctrl) begin
      tx_en_d = d32[0];
      rx_en_d = d32[16];
      baud_d  = d32[31:30];
      if (!tx_busy_i) begin
        tx_par_d  = d32[2];
        tx_stop_d = sat_stop(d32[4:3]);
        tx_dsel_d = d32[6:5];
      end
      if (!rx_busy_i) begin
        rx_par_d  = d32[18];
        rx_stop_d = sat_stop(d32[20:19]);
        rx_dsel_d = d32[22:21];
      end
    end
    if (wr_tx) tx_data_d = cpu_data_i[UART_DATA_WIDTH-1:0];
    if (rx_done_i) rx_data_d = rx_data_i;

    // Set events win over the clearing read; the read itself still sees the old flag.
    tx_done_d = tx_done_i || (tx_done_q && !rd_status);
    rx_ovr_d  = (rx_done_i && rx_done_q) || (rx_ovr_q && !rd_status);
    rx_done_d = rx_done_i || (rx_done_q && !rd_rx);

    case (cpu_addr_i)
      CPU_ADDR_WIDTH'(0): rd_word = {13'd0, rx_ovr_q, rx_busy_i, rx_done_q,
                                     14'd0, tx_busy_i, tx_done_q};
      CPU_ADDR_WIDTH'(1): rd_word = {baud_q, 7'd0, rx_dsel_q, rx_stop_q, rx_par_q, 1'b0, rx_en_q,
                                     9'd0, tx_dsel_q, tx_stop_q, tx_par_q, 1'b0, tx_en_q};
      CPU_ADDR_WIDTH'(2): rd_word = {{(32-UART_DATA_WIDTH){1'b0}}, tx_data_q};
      default:            rd_word = {{(32-UART_DATA_WIDTH){1'b0}}, rx_data_q};
    endcase
    if (rd_en_cpu_i) cpu_data_d = CPU_DATA_WIDTH'(rd_word);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      rx_start_q <= 1'b0;
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
      tx_stop_q  <= 2'd0;
      rx_stop_q  <= 2'd0;
      tx_dsel_q  <= 2'd0;
      rx_dsel_q  <= 2'd0;
      baud_q     <= 2'd0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      cpu_data_q <= '0;
    end else begin
      tx_en_q    <= tx_en_d;
      rx_en_q    <= rx_en_d;
      tx_start_q <= tx_start_d;
      rx_start_q <= rx_start_d;
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
      tx_stop_q  <= tx_stop_d;
      rx_stop_q  <= rx_stop_d;
      tx_dsel_q  <= tx_dsel_d;
      rx_dsel_q  <= rx_dsel_d;
      baud_q     <= baud_d;
      tx_data_q  <= tx_data_d;
      rx_data_q  <= rx_data_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
      rx_ovr_q   <= rx_ovr_d;
      cpu_data_q <= cpu_data_d;
    end
  end

  assign cpu_data_o     = cpu_data_q;
  assign tx_en_o        = tx_en_q;
  assign rx_en_o        = rx_en_q;
  assign tx_start_o     = tx_start_q;
  assign rx_start_o     = rx_start_q;
  assign tx_parity_en_o = tx_par_q;
  assign rx_parity_en_o = rx_par_q;
  assign tx_stop_sel_o  = tx_stop_q;
  assign rx_stop_sel_o  = rx_stop_q;
  assign tx_data_sel_o  = tx_dsel_q;
  assign rx_data_sel_o  = rx_dsel_q;
  assign baud_sel_o     = baud_q;
  assign tx_data_o      = tx_data_q;

endmodule

// File: tb/tb_uart_cpu_regs.sv
// Scoreboard bench for uart_cpu_regs: a driver feeds directed and random bus
// traffic into a rule-level model; a monitor compares the DUT after every edge.
module tb_uart_cpu_regs;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_en_cpu_i, rd_en_cpu_i;
  logic [1:0]  cpu_addr_i;
  logic [31:0] cpu_data_i, cpu_data_o;
  logic        tx_en_o, rx_en_o, tx_start_o, rx_start_o, tx_parity_en_o, rx_parity_en_o;
  logic [1:0]  tx_stop_sel_o, rx_stop_sel_o, tx_data_sel_o, rx_data_sel_o, baud_sel_o;
  logic [8:0]  tx_data_o, rx_data_i;
  logic        tx_done_i, rx_done_i, tx_busy_i, rx_busy_i;

  uart_cpu_regs dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_cpu_i(wr_en_cpu_i), .rd_en_cpu_i(rd_en_cpu_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .tx_en_o(tx_en_o), .rx_en_o(rx_en_o), .tx_start_o(tx_start_o), .rx_start_o(rx_start_o),
    .tx_parity_en_o(tx_parity_en_o), .rx_parity_en_o(rx_parity_en_o),
    .tx_stop_sel_o(tx_stop_sel_o), .rx_stop_sel_o(rx_stop_sel_o),
    .tx_data_sel_o(tx_data_sel_o), .rx_data_sel_o(rx_data_sel_o), .baud_sel_o(baud_sel_o),
    .tx_data_o(tx_data_o), .tx_done_i(tx_done_i), .rx_done_i(rx_done_i),
    .tx_busy_i(tx_busy_i), .rx_busy_i(rx_busy_i), .rx_data_i(rx_data_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // Reference model state (expected DUT state after the most recent edge).
  logic       m_txen, m_rxen, m_txstart, m_rxstart, m_txpar, m_rxpar;
  logic [1:0] m_txstop, m_rxstop, m_txds, m_rxds, m_baud;
  logic [8:0] m_txdata, m_rxdata;
  logic       m_txdone, m_rxdone, m_ovr;
  logic [31:0] m_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    {m_txen, m_rxen, m_txstart, m_rxstart, m_txpar, m_rxpar} = '0;
    {m_txstop, m_rxstop, m_txds, m_rxds, m_baud} = '0;
    m_txdata = '0; m_rxdata = '0;
    {m_txdone, m_rxdone, m_ovr} = '0;
    m_hold = '0;
  endtask

  function automatic logic [31:0] ctrl_word();
    return 32'(m_txen) | (32'(m_txpar) << 2) | (32'(m_txstop) << 3) | (32'(m_txds) << 5)
         | (32'(m_rxen) << 16) | (32'(m_rxpar) << 18) | (32'(m_rxstop) << 19)
         | (32'(m_rxds) << 21) | (32'(m_baud) << 30);
  endfunction

  function automatic logic [1:0] legal_stop(input logic [1:0] v);
    return (v > 2'd2) ? 2'd2 : v;
  endfunction

  task automatic model_step(input logic wr, rd, input logic [1:0] a, input logic [31:0] d,
                            input logic txd, rxd, txb, rxb, input logic [8:0] rxdat);
    logic [31:0] rv;
    logic old_rxdone;
    rv = 0;
    if (rd) begin
      case (a)
        2'd0: rv = 32'(m_txdone) | (32'(txb) << 1) | (32'(m_rxdone) << 16)
                 | (32'(rxb) << 17) | (32'(m_ovr) << 18);
        2'd1: rv = ctrl_word();
        2'd2: rv = 32'(m_txdata);
        default: rv = 32'(m_rxdata);
      endcase
      exp_q.push_back(rv);
      m_hold = rv;
    end
    m_txstart = wr && a == 2'd1 && d[1]  && (d[0]  || m_txen) && !txb;
    m_rxstart = wr && a == 2'd1 && d[17] && (d[16] || m_rxen) && !rxb;
    if (wr && a == 2'd1) begin
      m_txen = d[0]; m_rxen = d[16]; m_baud = d[31:30];
      if (!txb) begin m_txpar = d[2];  m_txstop = legal_stop(d[4:3]);   m_txds = d[6:5];   end
      if (!rxb) begin m_rxpar = d[18]; m_rxstop = legal_stop(d[20:19]); m_rxds = d[22:21]; end
    end
    if (wr && a == 2'd2) m_txdata = d[8:0];
    old_rxdone = m_rxdone;
    if (txd) m_txdone = 1'b1; else if (rd && a == 2'd0) m_txdone = 1'b0;
    if (rxd && old_rxdone) m_ovr = 1'b1; else if (rd && a == 2'd0) m_ovr = 1'b0;
    if (rxd) m_rxdone = 1'b1; else if (rd && a == 2'd3) m_rxdone = 1'b0;
    if (rxd) m_rxdata = rxdat;
  endtask

  // One bus cycle: drive inputs shortly after an edge, they are sampled on the next edge.
  task automatic cyc(input logic wr, rd, input logic [1:0] a, input logic [31:0] d,
                     input logic txd, rxd, txb, rxb, input logic [8:0] rxdat);
    @(posedge clk); #2;
    wr_en_cpu_i = wr; rd_en_cpu_i = rd; cpu_addr_i = a; cpu_data_i = d;
    tx_done_i = txd; rx_done_i = rxd; tx_busy_i = txb; rx_busy_i = rxb; rx_data_i = rxdat;
    model_step(wr, rd, a, d, txd, rxd, txb, rxb, rxdat);
  endtask

  task automatic idle_inputs();
    wr_en_cpu_i = 0; rd_en_cpu_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    tx_done_i = 0; rx_done_i = 0; tx_busy_i = 0; rx_busy_i = 0; rx_data_i = 0;
  endtask

  function automatic logic [31:0] outs_act();
    return 32'({tx_en_o, rx_en_o, tx_start_o, rx_start_o, tx_parity_en_o, rx_parity_en_o,
                tx_stop_sel_o, rx_stop_sel_o, tx_data_sel_o, rx_data_sel_o, baud_sel_o});
  endfunction

  function automatic logic [31:0] outs_exp();
    return 32'({m_txen, m_rxen, m_txstart, m_rxstart, m_txpar, m_rxpar,
                m_txstop, m_rxstop, m_txds, m_rxds, m_baud});
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl_outs"}, outs_act(), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
    chk({tag, "_cpu_data"}, cpu_data_o, 32'd0);
  endtask

  task automatic async_reset();
    @(posedge clk); #2;
    idle_inputs();
    #3;
    rst_i = 1'b1;
    model_zero();
    exp_q.delete();
    #1;
    check_all_zero("async_rst");
    #11;
    rst_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every read edge and checks all outputs.
  initial begin
    logic rd_seen;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      rd_seen = rd_en_cpu_i && !rst_i;
      #1;
      if (!rst_i) begin
        if (rd_seen) begin
          if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("read_data", cpu_data_o, e);
          end
        end
        chk("rd_hold", cpu_data_o, m_hold);
        chk("ctrl_outs", outs_act(), outs_exp());
        chk("tx_data_o", 32'(tx_data_o), 32'(m_txdata));
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    model_zero();
    #3;
    check_all_zero("reset");
    #9;
    rst_i = 1'b0;

    for (int a = 0; a < 4; a++) cyc(0, 1, 2'(a), 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'd1, 32'h4000_0069, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'd1, 32'h4000_0079, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'd2, 32'hFFFF_F1AA, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'd1, 32'h4000_0003, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'd1, 32'h4000_007B, 0, 0, 1, 0, 0);
    cyc(0, 1, 2'd1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0, 1, 0, 0, 9'h055);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd3, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0, 1, 0, 0, 9'h0AA);
    cyc(0, 0, 2'd0, 0, 0, 1, 0, 0, 9'h133);
    cyc(0, 1, 2'd0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2'd3, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2'd3, 0, 0, 1, 0, 0, 9'h1C3);
    cyc(1, 1, 2'd1, 32'h0003_0003, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0, 0);

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++)
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom(), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 9'($urandom()));
      if (pass == 0) async_reset();
    end

    cyc(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cpu_regs.md
Name: uart_cpu_regs

Overview:
CPU-facing register responder for the FPGA UART; it is the slave end of the wr_en/rd_en/addr/data bus that software or a testbench drives. It decodes 4 word registers (STATUS, CONTROL, TX, RX), holds the UART configuration and drives the TX/RX cores and the baud generator. It captures status and received data from the cores. It sits inside uart_top, between the CPU pins and the tx/rx/baud submodules.

Parameters:
CPU_ADDR_WIDTH, 2, register address width (word addresses 0..3)
CPU_DATA_WIDTH, 32, CPU data bus width
UART_DATA_WIDTH, 9, TX/RX data register width (8 data bits + parity/9th bit)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock, asynchronous, active-high
wr_en_cpu_i  in  1  write strobe, sampled on rising clk_i
rd_en_cpu_i  in  1  read strobe, sampled on rising clk_i
cpu_addr_i  in  CPU_ADDR_WIDTH  register address: 0 STATUS, 1 CONTROL, 2 TX, 3 RX
cpu_data_i  in  CPU_DATA_WIDTH  write data
cpu_data_o  out  CPU_DATA_WIDTH  registered read data
tx_en_o, rx_en_o  out  1  core enables (CONTROL bits 0, 16)
tx_start_o, rx_start_o  out  1  single-cycle start pulses
tx_parity_en_o, rx_parity_en_o  out  1  parity enables (bits 2, 18)
tx_stop_sel_o, rx_stop_sel_o  out  2  stop width select (bits 4:3, 20:19; 0=1b, 1=2b, 2=3b)
tx_data_sel_o, rx_data_sel_o  out  2  data width select (bits 6:5, 22:21; 0=5b..3=8b)
baud_sel_o  out  2  baud select (bits 31:30; 0=9600, 1=19200, 2=115200, 3=256000)
tx_data_o  out  UART_DATA_WIDTH  TX data register
tx_done_i, rx_done_i  in  1  single-cycle completion pulses from the cores
tx_busy_i, rx_busy_i  in  1  core busy levels
rx_data_i  in  UART_DATA_WIDTH  received word, valid while rx_done_i is high

Behaviour:
- Reset (async, immediate): every output is 0; all registers and sticky flags are 0.
- Write: on a rising edge with wr_en_cpu_i=1, the addressed register updates. The new value is visible on the outputs 1 cycle later. Writes to STATUS and RX are ignored.
- Read: on a rising edge with rd_en_cpu_i=1, cpu_data_o loads the addressed register (1-cycle latency). cpu_data_o holds that value until the next read.
  - Unused bits read 0.
  - Start bits (1, 17) always read 0.
- Read and write in the same cycle, same address: the read returns the pre-write value; the write still takes effect.
- STATUS (RO) fields:
  - bit0 tx_done: sticky; set by tx_done_i.
  - bit1 = tx_busy_i.
  - bit16 rx_done: sticky; set by rx_done_i.
  - bit17 = rx_busy_i.
  - bit18 rx_overrun: sticky; set when rx_done_i arrives while rx_done is already set.
- Sticky clear rules:
  - A STATUS read clears tx_done and rx_overrun.
  - A RX read clears rx_done.
  - If a set event coincides with its clearing read, the read returns the old value and the flag ends the cycle set.
- CONTROL start handling:
  - Writing bit1=1 pulses tx_start_o for exactly 1 cycle, only if the written tx_en=1 (or tx_en is already 1) and tx_busy_i=0. Otherwise the start is dropped silently.
  - rx_start_o follows the same rule using bits 17/16 and rx_busy_i.
- CONTROL config fields:
  - tx_parity, tx_stop and tx_data fields are locked (writes ignored) while tx_busy_i=1.
  - The rx fields are likewise locked while rx_busy_i=1.
  - The enable bits and baud_sel are always writable.
- Stop-field value 3 is illegal: it is stored as 2 (tx and rx independently).
- Clearing an enable bit deasserts the corresponding *_en_o on the next cycle, regardless of busy.
- TX register: stores cpu_data_i[8:0]; bits above 8 are discarded.
- RX register: loads rx_data_i on rx_done_i. A new rx_done_i overwrites unread data (rx_overrun flags it).
- Address decode is full: all 4 addresses are valid; no error response.

Test Plan:
- Reset, then read all 4 addresses -> cpu_data_o=0x00000000 each, 1 cycle after rd_en; all outputs 0.
- Write CONTROL=0x4000_0069 -> tx_en_o=1, tx_stop_sel_o=1, tx_data_sel_o=3, baud_sel_o=1; readback returns 0x4000_0069. Write stop field=3 -> readback shows 2.
- Write TX=0x1AA, then CONTROL with bits0,1 set and tx_busy_i=0 -> tx_data_o=0x1AA; tx_start_o high exactly 1 cycle; readback bit1=0. Repeat with tx_busy_i=1 -> no pulse.
- Pulse tx_done_i -> STATUS read = 0x0000_0001; a second STATUS read = 0x0000_0000. tx_done_i coincident with the STATUS read -> returns 0, the next read returns 1.
- rx_done_i with rx_data_i=0x055 -> STATUS bit16=1, RX read=0x0000_0055, rx_done clears. Two rx_done_i pulses without a RX read -> bit18=1, RX holds the second word.
- Assert rst_i mid-transfer, between clock edges -> all outputs 0 immediately, with no clock edge required.
